rns_mrc_sign_detect: RTL and testbench

- Upstream neighbour of the 8-lane RNS subtract-correction stage.
- Takes one 8-digit RNS word, 18 bits per digit, and determines its sign by iterative mixed-radix conversion (MRC), one MRC step per cycle.
- Emits the unmodified digits plus a 2-bit sign code that drives the correction stage's digit inputs and sign_in.
- Valid/ready handshake on both sides; one word in flight.

---
 rtl/rns_mrc_sign_detect_if.sv | 13 +
 rtl/rns_mrc_sign_detect.sv | 139 +++++++++++++
 tb/tb_rns_mrc_sign_detect.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rns_mrc_sign_detect_if.sv
// rns_mrc_sign_detect_if: word-in / word-out handshake bundle for the RNS sign detector
interface rns_mrc_sign_detect_if #(parameter int DW = 18);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dig_in [8];
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] dig_out [8];
   logic [1:0]    sign_out;
   logic [DW-1:0] mr_top;
   modport master (output in_valid, dig_in, out_ready, input in_ready, out_valid, dig_out, sign_out, mr_top);
   modport slave  (input in_valid, dig_in, out_ready, output in_ready, out_valid, dig_out, sign_out, mr_top);
endinterface

// File: rtl/rns_mrc_sign_detect.sv
// rns_mrc_sign_detect: 8-lane RNS sign detection by mixed-radix conversion, one MRC step per cycle
module rns_mrc_sign_detect #(
   parameter longint M0 = 177147,
   parameter longint M1 = 78125,
   parameter longint M2 = 117649,
   parameter longint M3 = 161051,
   parameter longint M4 = 131071,
   parameter longint M5 = 65537,
   parameter longint M6 = 65521,
   parameter longint M7 = 262144,
   parameter int     DW = 18
) (
   input logic clk,
   input logic reset,
   rns_mrc_sign_detect_if.slave bus
);
   localparam longint mods [8] = '{M0, M1, M2, M3, M4, M5, M6, M7};
   localparam logic [35:0] mw [8] = '{36'(M0), 36'(M1), 36'(M2), 36'(M3), 36'(M4), 36'(M5), 36'(M6), 36'(M7)};

   function automatic longint gcd(longint a, longint b);
      longint t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic longint inv_mod(longint a, longint m);
      longint t = 0, nt = 1, r = m, nr = a % m, q, tmp;
      while (nr != 0) begin
         q = r / nr;
         tmp = t - q * nt;
         t = nt;
         nt = tmp;
         tmp = r - q * nr;
         r = nr;
         nr = tmp;
      end
      return (t < 0) ? t + m : t;
   endfunction

   if (M7 % 2 != 0) begin : g_odd
      $error("top modulus M7 must be even");
   end
   for (genvar a = 0; a < 8; a++) begin : g_ca
      for (genvar b = a + 1; b < 8; b++) begin : g_cb
         if (gcd(mods[a], mods[b]) != 1) begin : g_bad
            $error("moduli %0d and %0d are not coprime", a, b);
         end
      end
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state;
   logic [2:0]    step;
   logic [DW-1:0] w [8];
   logic [DW-1:0] nxt [8];
   logic [DW-1:0] hold [8];
   logic [DW-1:0] mr_top;
   logic [1:0]    sign_out;
   logic          out_valid, range_err, in_range_err, zero;

   always_comb begin
      in_range_err = 1'b0;
      zero = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_range_err = in_range_err | (36'(bus.dig_in[k]) >= mw[k]);
         zero = zero & (nxt[k] == '0);
      end
   end

   // lane j subtracts digit a_step (reduced into its own modulus) and divides by M_step
   for (genvar j = 0; j < 8; j++) begin : g_lane
      if (j == 0) begin : g_base
         assign nxt[0] = w[0];
      end else begin : g_upd
         logic [DW-1:0] iv [8];
         logic [DW-1:0] wk, d;
         logic [35:0]   prod;
         for (genvar k = 0; k < 8; k++) begin : g_inv
            if (k < j) begin : g_v
               assign iv[k] = DW'(inv_mod(mods[k], mods[j]));
            end else begin : g_z
               assign iv[k] = '0;
            end
         end
         assign wk = DW'(36'(w[step]) % mw[j]);
         assign d = (w[j] >= wk) ? w[j] - wk : DW'(36'(w[j]) + mw[j] - 36'(wk));
         assign prod = 36'(d) * 36'(iv[step]);
         assign nxt[j] = (3'(j) > step) ? DW'(prod % mw[j]) : w[j];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         step <= '0;
         out_valid <= 1'b0;
         sign_out <= 2'b00;
         mr_top <= '0;
         range_err <= 1'b0;
         hold <= '{default: '0};
         w <= '{default: '0};
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               hold <= bus.dig_in;
               w <= bus.dig_in;
               range_err <= in_range_err;
               step <= '0;
               state <= RUN;
            end
            RUN: begin
               w <= nxt;
               step <= step + 3'd1;
               if (step == 3'd6) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  mr_top <= nxt[7];
                  sign_out <= range_err ? 2'b11 : zero ? 2'b10 : (36'(nxt[7]) >= (mw[7] >> 1)) ? 2'b01 : 2'b00;
               end
            end
            DONE: if (bus.out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !reset;
   assign bus.out_valid = out_valid;
   assign bus.dig_out   = hold;
   assign bus.sign_out  = sign_out;
   assign bus.mr_top    = mr_top;
endmodule

// File: tb/tb_rns_mrc_sign_detect.sv
// tb_rns_mrc_sign_detect: directed scoreboard bench for the RNS MRC sign detector
module tb_rns_mrc_sign_detect;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rns_mrc_sign_detect_if bus ();
   rns_mrc_sign_detect dut (.clk(clk), .reset(reset), .bus(bus));

   localparam logic [17:0] mods [8] = '{18'd177147, 18'd78125, 18'd117649, 18'd161051, 18'd131071, 18'd65537, 18'd65521, 18'd0};

   typedef struct {
      logic [1:0]  sign;
      logic [17:0] mr;
      logic        mr_chk;
      logic [17:0] dig [8];
   } exp_t;

   exp_t q[$];
   int tests = 0, fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [17:0] d [8], input logic [1:0] s, input logic [17:0] mr, input logic mr_chk);
      int n = 0;
      exp_t e;
      bus.dig_in = d;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_pre_accept", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      e.sign = s;
      e.mr = mr;
      e.mr_chk = mr_chk;
      e.dig = d;
      q.push_back(e);
   endtask

   task automatic expect_out();
      int n = 0;
      exp_t e;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency_edges", n, 7);
      check("in_ready_in_done", bus.in_ready, 0);
      if (q.size() == 0) check("scoreboard_nonempty", 0, 1);
      else begin
         e = q.pop_front();
         check("sign_out", bus.sign_out, e.sign);
         if (e.mr_chk) check("mr_top", bus.mr_top, e.mr);
         for (int k = 0; k < 8; k++) check($sformatf("dig_out_%0d", k), bus.dig_out[k], e.dig[k]);
      end
   endtask

   task automatic handshake(input logic [17:0] held0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("out_valid_after_hs", bus.out_valid, 0);
      check("in_ready_after_hs", bus.in_ready, 1);
      check("dig_out_held_after_hs", bus.dig_out[0], held0);
   endtask

   initial begin
      logic [17:0] d [8];
      logic [1:0]  s_hold;
      logic [17:0] mr_hold;
      logic        stable, seen;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.dig_in = '{default: '0};
      @(posedge clk); @(posedge clk); #1;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_sign_out", bus.sign_out, 0);
      check("rst_mr_top", bus.mr_top, 0);
      for (int k = 0; k < 8; k++) check($sformatf("rst_dig_out_%0d", k), bus.dig_out[k], 0);
      reset = 1'b0;
      #1;
      check("in_ready_after_rst", bus.in_ready, 1);

      d = '{default: '0};
      send(d, 2'b10, 18'd0, 1'b1);
      expect_out();
      handshake(d[0]);

      d = '{default: 18'd1};
      send(d, 2'b00, 18'd0, 1'b1);
      expect_out();
      handshake(d[0]);

      for (int k = 0; k < 8; k++) d[k] = mods[k] - 18'd1;
      send(d, 2'b01, 18'd262143, 1'b1);
      expect_out();
      handshake(d[0]);

      d = '{default: '0};
      d[7] = 18'd131072;
      send(d, 2'b01, 18'd131072, 1'b1);
      expect_out();
      handshake(d[0]);

      for (int k = 0; k < 7; k++) d[k] = mods[k] - 18'd1;
      d[7] = 18'd131071;
      send(d, 2'b00, 18'd131071, 1'b1);
      expect_out();
      handshake(d[0]);

      // backpressure: result must hold while a competing word is offered
      bus.out_ready = 1'b0;
      d = '{default: 18'd2};
      send(d, 2'b00, 18'd0, 1'b1);
      expect_out();
      s_hold = bus.sign_out;
      mr_hold = bus.mr_top;
      stable = 1'b1;
      bus.dig_in = '{default: 18'd5};
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         stable &= bus.out_valid && !bus.in_ready && bus.sign_out == s_hold && bus.mr_top == mr_hold && bus.dig_out[3] == 18'd2;
      end
      check("backpressure_stable", stable, 1);
      handshake(18'd2);
      bus.in_valid = 1'b0;
      check("ignored_word_dig_out_3", bus.dig_out[3], 18'd2);

      d = '{default: '0};
      d[1] = 18'd78125;
      send(d, 2'b11, 18'd0, 1'b0);
      expect_out();
      handshake(d[0]);

      // reset during RUN discards the word
      d = '{default: 18'd1};
      send(d, 2'b00, 18'd0, 1'b1);
      void'(q.pop_back());
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("in_ready_after_mid_rst", bus.in_ready, 1);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         seen |= bus.out_valid;
      end
      check("no_out_after_mid_rst", seen, 0);
      send(d, 2'b00, 18'd0, 1'b1);
      expect_out();
      handshake(d[0]);

      check("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
